// File: rtl/ac97_pkg.sv
// Shared AC'97 frame geometry, tag bit positions and the codec command record.
// Slot start positions are bit_cnt values of the slot's bit 19.
package ac97_pkg;

  localparam int FRAME_BITS  = 256;
  localparam int TAG_BITS    = 16;
  localparam int SLOT_BITS   = 20;
  localparam int SLOT1_START = TAG_BITS;
  localparam int SLOT2_START = SLOT1_START + SLOT_BITS;
  localparam int SLOT3_START = SLOT2_START + SLOT_BITS;
  localparam int SLOT4_START = SLOT3_START + SLOT_BITS;
  localparam int SLOT5_START = SLOT4_START + SLOT_BITS;
  // Everything from slot 5 onward is transmitted as zero.
  localparam int HEAD_BITS   = SLOT5_START;

  localparam logic [7:0] CNT_LAST = 8'(FRAME_BITS - 1);
  localparam logic [7:0] SYNC_END = 8'd14;

  localparam int TAG_VALID = 15;
  localparam int TAG_SLOT1 = 14;
  localparam int TAG_SLOT2 = 13;
  localparam int TAG_SLOT3 = 12;
  localparam int TAG_SLOT4 = 11;

  typedef struct packed {
    logic        rd;
    logic [6:0]  addr;
    logic [15:0] data;
  } cmd_t;

  function automatic logic [15:0] build_tag(input logic en, input logic cmd,
                                            input logic rd, input logic [1:0] id);
    logic [15:0] t;
    t            = 16'h0000;
    t[TAG_VALID] = en | cmd;
    t[TAG_SLOT1] = cmd;
    t[TAG_SLOT2] = cmd & ~rd;
    t[TAG_SLOT3] = en;
    t[TAG_SLOT4] = en;
    t[1:0]       = id;
    return t;
  endfunction

endpackage

// File: rtl/ac97_frame_counter.sv
// Free-running 256-bit frame position counter with SYNC, strobe and latch-point decode.
module ac97_frame_counter
  import ac97_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  output logic [7:0] bit_cnt_o,
  output logic       latch_o,
  output logic       sync_o,
  output logic       strobe_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       sync_q, sync_d;

  // Next count and SYNC decode; SYNC is registered so it lags the count by one cycle.
  always_comb begin
    cnt_d  = cnt_q + 8'd1;
    sync_d = (cnt_q == CNT_LAST) || (cnt_q <= SYNC_END);
  end

  // Counter and SYNC registers; reset parks on the latch point.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= CNT_LAST;
      sync_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign bit_cnt_o = cnt_q;
  assign latch_o   = (cnt_q == CNT_LAST);
  assign sync_o    = sync_q;
  // Gated by reset so the strobe is quiet while held but fires in the first cycle after release.
  assign strobe_o  = latch_o & rst_n_i;

endmodule

// File: rtl/ac97_frame_tx.sv
// AC'97 SDATA_OUT frame serializer: PCM slots 3/4 plus a one-deep codec register command buffer.
// All frame content comes from shadow registers loaded at the latch point.
module ac97_frame_tx
  import ac97_pkg::*;
#(
  parameter logic [1:0] CODEC_ID = 2'b00
) (
  input  logic        I_BITCLK,
  input  logic        I_RESET_N,
  input  logic        I_ENABLE,
  input  logic [19:0] I_LEFT_SAMPLE,
  input  logic [19:0] I_RIGHT_SAMPLE,
  output logic        O_STROBE,
  input  logic        I_CMD_VALID,
  input  logic        I_CMD_RD,
  input  logic [6:0]  I_CMD_ADDR,
  input  logic [15:0] I_CMD_DATA,
  output logic        O_CMD_READY,
  output logic        O_SYNC,
  output logic        O_SDATA
);

  logic [7:0] bit_cnt_s;
  logic       latch_s;
  logic       sync_s;
  logic       strobe_s;

  ac97_frame_counter u_counter (
    .clk_i     (I_BITCLK),
    .rst_n_i   (I_RESET_N),
    .bit_cnt_o (bit_cnt_s),
    .latch_o   (latch_s),
    .sync_o    (sync_s),
    .strobe_o  (strobe_s)
  );

  logic        en_q, en_d;
  logic [19:0] left_q, left_d;
  logic [19:0] right_q, right_d;
  logic        pend_q, pend_d;
  cmd_t        buf_q, buf_d;
  logic        fcmd_q, fcmd_d;
  cmd_t        frame_q, frame_d;
  logic        sdata_q, sdata_d;

  logic        accept_s;
  logic [15:0] tag_s;
  logic [19:0] slot1_s, slot2_s, slot3_s, slot4_s;
  logic [HEAD_BITS-1:0] head_s;

  assign O_CMD_READY = I_RESET_N & ~pend_q;
  assign accept_s    = I_CMD_VALID & O_CMD_READY;

  // Shadow and command-buffer next state; an accept at the latch point is kept for the next frame.
  always_comb begin
    en_d    = en_q;
    left_d  = left_q;
    right_d = right_q;
    fcmd_d  = fcmd_q;
    frame_d = frame_q;
    pend_d  = pend_q;
    buf_d   = buf_q;
    if (latch_s) begin
      en_d    = I_ENABLE;
      left_d  = I_LEFT_SAMPLE;
      right_d = I_RIGHT_SAMPLE;
      fcmd_d  = pend_q;
      if (pend_q) begin
        frame_d = buf_q;
      end else begin
        frame_d = frame_q;
      end
    end else begin
      fcmd_d  = fcmd_q;
    end
    if (accept_s) begin
      pend_d = 1'b1;
      buf_d  = '{rd: I_CMD_RD, addr: I_CMD_ADDR, data: I_CMD_DATA};
    end else if (latch_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // Tag and slots 1..4 from the shadows, then the bit selected by the current count.
  always_comb begin
    tag_s   = build_tag(en_q, fcmd_q, frame_q.rd, CODEC_ID);
    slot1_s = fcmd_q ? {frame_q.rd, frame_q.addr, 12'h000} : 20'h00000;
    slot2_s = (fcmd_q && !frame_q.rd) ? {frame_q.data, 4'h0} : 20'h00000;
    slot3_s = en_q ? left_q : 20'h00000;
    slot4_s = en_q ? right_q : 20'h00000;
    head_s  = {tag_s, slot1_s, slot2_s, slot3_s, slot4_s};
    if (bit_cnt_s < 8'(HEAD_BITS)) begin
      sdata_d = head_s[7'(HEAD_BITS - 1) - bit_cnt_s[6:0]];
    end else begin
      sdata_d = 1'b0;
    end
  end

  // State registers; reset drops any pending or in-flight command.
  always_ff @(posedge I_BITCLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      en_q    <= 1'b0;
      left_q  <= 20'h00000;
      right_q <= 20'h00000;
      pend_q  <= 1'b0;
      buf_q   <= '0;
      fcmd_q  <= 1'b0;
      frame_q <= '0;
      sdata_q <= 1'b0;
    end else begin
      en_q    <= en_d;
      left_q  <= left_d;
      right_q <= right_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      fcmd_q  <= fcmd_d;
      frame_q <= frame_d;
      sdata_q <= sdata_d;
    end
  end

  assign O_SDATA  = sdata_q;
  assign O_SYNC   = sync_s;
  assign O_STROBE = strobe_s;

endmodule

// File: tb/tb_ac97_frame_tx.sv
// Directed bench for ac97_frame_tx: captures whole frames off SDATA and checks tag/slot fields.
module tb_ac97_frame_tx;

  logic        clk, rst_n, en, strobe;
  logic [19:0] left, right;
  logic        cmd_valid, cmd_rd, cmd_ready, sync, sdata;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_data;

  int checks;
  int failures;

  logic [255:0] frm;
  logic [255:0] syncm;
  int           strobe_hits;
  logic         strobe_at_end;
  logic         ready_c1;

  localparam logic [255:0] SYNC_EXP = 256'hFFFF;

  ac97_frame_tx #(.CODEC_ID(2'b00)) dut (
    .I_BITCLK       (clk),
    .I_RESET_N      (rst_n),
    .I_ENABLE       (en),
    .I_LEFT_SAMPLE  (left),
    .I_RIGHT_SAMPLE (right),
    .O_STROBE       (strobe),
    .I_CMD_VALID    (cmd_valid),
    .I_CMD_RD       (cmd_rd),
    .I_CMD_ADDR     (cmd_addr),
    .I_CMD_DATA     (cmd_data),
    .O_CMD_READY    (cmd_ready),
    .O_SYNC         (sync),
    .O_SDATA        (sdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] field(input logic [255:0] f, input int start, input int len);
    logic [19:0] v;
    v = 20'h00000;
    for (int i = 0; i < len; i++) v = {v[18:0], f[start + i]};
    return v;
  endfunction

  task automatic wait_strobe();
    int n;
    n = 0;
    @(negedge clk);
    while (strobe !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (strobe !== 1'b1) begin
      failures++;
      $display("FAIL wait_strobe: got %b required 1 within 400 cycles", strobe);
    end
  endtask

  // Must be called from within the strobe cycle; returns in the next strobe cycle.
  task automatic capture();
    frm = '0;
    syncm = '0;
    strobe_hits = 0;
    strobe_at_end = 1'b0;
    ready_c1 = 1'b0;
    for (int c = 1; c <= 256; c++) begin
      @(negedge clk);
      if (c == 1) ready_c1 = cmd_ready;
      if (c >= 2) frm[c - 2] = sdata;
      syncm[c - 1] = sync;
      if (strobe === 1'b1) strobe_hits++;
      if (c == 256) strobe_at_end = strobe;
    end
  endtask

  task automatic check_slots(input string name, input logic [19:0] tag, input logic [19:0] s1,
                             input logic [19:0] s2, input logic [19:0] s3, input logic [19:0] s4);
    checks++;
    if (field(frm, 0, 16) !== tag) begin
      failures++;
      $display("FAIL %s_tag: got %h required %h", name, field(frm, 0, 16), tag);
    end
    checks++;
    if (field(frm, 16, 20) !== s1) begin
      failures++;
      $display("FAIL %s_slot1: got %h required %h", name, field(frm, 16, 20), s1);
    end
    checks++;
    if (field(frm, 36, 20) !== s2) begin
      failures++;
      $display("FAIL %s_slot2: got %h required %h", name, field(frm, 36, 20), s2);
    end
    checks++;
    if (field(frm, 56, 20) !== s3) begin
      failures++;
      $display("FAIL %s_slot3: got %h required %h", name, field(frm, 56, 20), s3);
    end
    checks++;
    if (field(frm, 76, 20) !== s4) begin
      failures++;
      $display("FAIL %s_slot4: got %h required %h", name, field(frm, 76, 20), s4);
    end
    checks++;
    if (frm[255:96] !== 160'h0) begin
      failures++;
      $display("FAIL %s_tail: got %h required 0", name, frm[255:96]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; left = 20'h0; right = 20'h0;
    cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_addr = 7'h00; cmd_data = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({sdata, sync, strobe, cmd_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 0000", {sdata, sync, strobe, cmd_ready});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({strobe, cmd_ready} !== 2'b11) begin
      failures++;
      $display("FAIL release_strobe_ready: got %b required 11", {strobe, cmd_ready});
    end
  endtask

  task automatic test_idle_frame();
    capture();
    check_slots("idle", 20'h00000, 20'h0, 20'h0, 20'h0, 20'h0);
    checks++;
    if (syncm !== SYNC_EXP) begin
      failures++;
      $display("FAIL idle_sync: got %h required %h", syncm, SYNC_EXP);
    end
    checks++;
    if (strobe_hits !== 1 || strobe_at_end !== 1'b1) begin
      failures++;
      $display("FAIL idle_strobe: got hits=%0d end=%b required hits=1 end=1", strobe_hits, strobe_at_end);
    end
  endtask

  task automatic test_enable_pcm();
    en = 1'b1; left = 20'h7FFFF; right = 20'h80001;
    wait_strobe();
    capture();
    check_slots("pcm", 20'h09800, 20'h0, 20'h0, 20'h7FFFF, 20'h80001);
    checks++;
    if (syncm !== SYNC_EXP) begin
      failures++;
      $display("FAIL pcm_sync: got %h required %h", syncm, SYNC_EXP);
    end
  endtask

  task automatic test_cmd_write();
    en = 1'b0;
    wait_strobe();
    repeat (10) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL wr_ready_idle: got %b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_addr = 7'h02; cmd_data = 16'h8000;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL wr_ready_after_accept: got %b required 0", cmd_ready);
    end
    wait_strobe();
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL wr_ready_at_latch: got %b required 0", cmd_ready);
    end
    capture();
    checks++;
    if (ready_c1 !== 1'b1) begin
      failures++;
      $display("FAIL wr_ready_after_latch: got %b required 1", ready_c1);
    end
    check_slots("wr", 20'h0E000, 20'h02000, 20'h80000, 20'h0, 20'h0);
  endtask

  task automatic test_cmd_read();
    en = 1'b1; left = 20'h12345; right = 20'hABCDE;
    wait_strobe();
    repeat (5) @(negedge clk);
    cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_addr = 7'h7C; cmd_data = 16'hFFFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_strobe();
    capture();
    check_slots("rd", 20'h0D800, 20'hFC000, 20'h0, 20'h12345, 20'hABCDE);
  endtask

  task automatic test_cmd_at_latch();
    en = 1'b0;
    wait_strobe();
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_addr = 7'h15; cmd_data = 16'h1234;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL latch_accept_ready: got %b required 0", cmd_ready);
    end
    capture();
    check_slots("latch_cur", 20'h00000, 20'h0, 20'h0, 20'h0, 20'h0);
    capture();
    check_slots("latch_next", 20'h0E000, 20'h15000, 20'h12340, 20'h0, 20'h0);
  endtask

  task automatic test_sample_update();
    en = 1'b1; left = 20'h11111; right = 20'h22222;
    wait_strobe();
    @(posedge clk);
    #1;
    left = 20'h33333; right = 20'h44444;
    capture();
    check_slots("upd_old", 20'h09800, 20'h0, 20'h0, 20'h11111, 20'h22222);
    capture();
    check_slots("upd_new", 20'h09800, 20'h0, 20'h0, 20'h33333, 20'h44444);
  endtask

  task automatic test_reset_midframe();
    en = 1'b0;
    wait_strobe();
    repeat (51) @(negedge clk);
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_addr = 7'h2A; cmd_data = 16'h5A5A;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_pending: got %b required 0", cmd_ready);
    end
    repeat (49) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sdata, sync, strobe, cmd_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset_outputs: got %b required 0000", {sdata, sync, strobe, cmd_ready});
    end
    en = 1'b1; left = 20'h0ABCD; right = 20'hF0F0F;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({strobe, cmd_ready} !== 2'b11) begin
      failures++;
      $display("FAIL mid_release: got %b required 11", {strobe, cmd_ready});
    end
    capture();
    check_slots("mid_restart", 20'h09800, 20'h0, 20'h0, 20'h0ABCD, 20'hF0F0F);
    checks++;
    if (syncm !== SYNC_EXP) begin
      failures++;
      $display("FAIL mid_sync: got %h required %h", syncm, SYNC_EXP);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_idle_frame();
    test_enable_pcm();
    test_cmd_write();
    test_cmd_read();
    test_cmd_at_latch();
    test_sample_update();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ac97_frame_tx.md
AC97_FRAME_TX -- requirements
Module: ac97_frame_tx

Interface
REQ-001 Parameter: CODEC_ID, default 2'b00, codec ID placed in tag bits 1:0.
REQ-002 Port: I_BITCLK  in  1  AC'97 bit clock (12.288 MHz), the only clock; all logic on rising edge.
REQ-003 Port: I_RESET_N  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: I_ENABLE  in  1  PCM playback enable; sampled at latch point.
REQ-005 Port: I_LEFT_SAMPLE  in  20  signed PCM left (slot 3).
REQ-006 Port: I_RIGHT_SAMPLE  in  20  signed PCM right (slot 4).
REQ-007 Port: O_STROBE  out  1  one-cycle sample-rate pulse (48 kHz) to waveform generators.
REQ-008 Port: I_CMD_VALID  in  1  codec register command request.
REQ-009 Port: I_CMD_RD  in  1  1 = read, 0 = write.
REQ-010 Port: I_CMD_ADDR  in  7  codec register index.
REQ-011 Port: I_CMD_DATA  in  16  write data.
REQ-012 Port: O_CMD_READY  out  1  command buffer empty.
REQ-013 Port: O_SYNC  out  1  AC'97 SYNC.
REQ-014 Port: O_SDATA  out  1  AC'97 SDATA_OUT, MSB first.

Function
REQ-015 8-bit bit_cnt SHALL increment every cycle, wrapping 255->0; one frame = 256 bits.
REQ-016 Frame layout SHALL be: bit_cnt 0..15 = tag bits 15..0; slot k (1..12) = bit_cnt 16+20(k-1) .. 35+20(k-1), slot bit 19 first.
REQ-017 O_SDATA SHALL be registered and equal the frame bit selected by bit_cnt of the previous cycle.
REQ-018 O_SYNC SHALL be registered and high for bit_cnt in {255, 0..14}: 16 cycles, leading tag bit 15 by one cycle.
REQ-019 Latch point = cycle with bit_cnt==255; O_STROBE SHALL be high for exactly that cycle.
REQ-020 At latch point, I_LEFT_SAMPLE, I_RIGHT_SAMPLE and I_ENABLE SHALL be captured into shadow registers (pre-update values); the shadows alone drive the following frame.
REQ-021 Command handshake: accept on I_CMD_VALID && O_CMD_READY; capture RD/ADDR/DATA; O_CMD_READY low the next cycle.
REQ-022 A pending command SHALL be moved into the frame at the next latch point, buffer cleared; O_CMD_READY high the cycle after.
REQ-023 A command accepted in the latch-point cycle itself SHALL go out in the following frame, not the current one.
REQ-024 Tag SHALL be: bit15 = enable || cmd; bit14 = cmd; bit13 = cmd && !rd; bit12 = bit11 = enable; bits 10:2 = 0; bits 1:0 = CODEC_ID.
REQ-025 Slot 1 SHALL be {rd, addr[6:0], 12'h000} when cmd, else 0.
REQ-026 Slot 2 SHALL be {data[15:0], 4'h0} when cmd && !rd, else 0.
REQ-027 Slots 3/4 SHALL carry the shadow samples when enable, else 0.
REQ-028 Slots 5..12 SHALL be 0.
REQ-029 SYNC and O_STROBE SHALL continue while I_ENABLE = 0.

Reset
REQ-030 Asserted: bit_cnt = 255, shadows = 0, cmd buffer empty, O_SDATA = 0, O_SYNC = 0, O_STROBE = 0, O_CMD_READY = 0.
REQ-031 First cycle after deassertion SHALL be a latch point, so frame 0 starts immediately; O_CMD_READY high from that cycle.
REQ-032 Reset mid-frame SHALL abort the frame and drop any pending command without transmitting it.

Structure
REQ-033 Shared package ac97_pkg SHALL hold FRAME_BITS=256, TAG_BITS=16, SLOT_BITS=20, slot start constants, and tag bit indices.
REQ-034 One sub-module, ac97_frame_counter, SHALL own bit_cnt and the decode of O_SYNC, O_STROBE and latch point.

Verification
REQ-035 Reset release, I_ENABLE = 0 -> O_STROBE every 256 cycles; SYNC high for 16 cycles; SDATA all 0 except CODEC_ID bits.
REQ-036 I_ENABLE = 1, L = 20'h7FFFF, R = 20'h80001 -> tag 16'h9800 (CODEC_ID = 0); slot 3 = 7FFFF and slot 4 = 80001 MSB first at bit_cnt 56 / 76.
REQ-037 Write addr 7'h02, data 16'h8000 -> tag bits 15:13 = 111; slot 1 = 20'h02000; slot 2 = 20'h80000; ready low until latch point, high the cycle after.
REQ-038 Read addr 7'h7C -> slot 1 = 20'hFC000; tag bit 13 = 0; slot 2 = 0.
REQ-039 Sample change on the O_STROBE cycle (generator-style update) -> that frame carries the old value, the next frame the new one.
REQ-040 I_RESET_N low at bit_cnt = 100 with a command pending -> outputs 0 asynchronously; restart per REQ-031; no command slots sent.
